csr_trap_unit: RTL and testbench

- Write-back-stage consumer of the decode control outputs: wr_csr_n, is_illegal_ir, is_ecall, is_mret.
- Holds the machine-mode CSRs and executes CSR read/modify/write.
- Takes illegal-instruction and ecall traps and executes mret.
- Issues a registered one-cycle PC redirect to fetch; the same pulse flushes the pipeline.

---
 rtl/csr_trap_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file plus trap/mret sequencing at write-back.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   valid               an instruction retires in write-back this cycle
//   pc, ir              PC and raw instruction word of the retiring instruction
//   funct3, csr_addr    CSR op select and CSR address (ir[31:20])
//   rs1_data, zimm      register and immediate write operands
//   wr_csr_n            0 = perform the CSR write
//   is_illegal_ir       instruction is illegal (takes a trap)
//   is_ecall            instruction is ecall (takes a trap)
//   is_mret             instruction is mret
//   csr_rdata           combinational pre-write CSR value for rd write-back
//   redirect            registered one-cycle PC redirect / pipeline flush
//   redirect_pc         redirect target, valid while redirect is high
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        wr_csr_n,
  input  logic        is_illegal_ir,
  input  logic        is_ecall,
  input  logic        is_mret,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 64;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [XLEN-1:0] MTVEC_INIT   = MTVEC_RESET & 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [XLEN-1:0] CAUSE_ECALL   = 32'd11;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t state;

  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [CW-1:0]   mcycle;
  logic [CW-1:0]   minstret;

  logic            run;
  logic            trap;
  logic            mret_fire;
  logic            retire;
  logic            csr_we;
  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] wdata;

  // The low PC bits never reach mepc since mepc is always word aligned.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^pc[1:0];

  // Event decode; nothing fires while the flushed slot is in REDIRECT.
  always_comb begin
    run       = (state == RUN);
    trap      = valid && run && (is_illegal_ir || is_ecall);
    mret_fire = valid && run && is_mret && !trap;
    retire    = valid && run && !trap;
    csr_we    = valid && run && !wr_csr_n && !trap && (funct3[1:0] != 2'b00);
  end

  // mstatus view: MPP hard-wired to machine mode, only MIE/MPIE live.
  always_comb begin
    mstatus_rd     = '0;
    mstatus_rd[12] = 1'b1;
    mstatus_rd[11] = 1'b1;
    mstatus_rd[7]  = mpie;
    mstatus_rd[3]  = mie;
  end

  // Pre-write read mux; unimplemented addresses read zero.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS:   csr_rdata = mstatus_rd;
      ADDR_MTVEC:     csr_rdata = mtvec;
      ADDR_MSCRATCH:  csr_rdata = mscratch;
      ADDR_MEPC:      csr_rdata = mepc;
      ADDR_MCAUSE:    csr_rdata = mcause;
      ADDR_MTVAL:     csr_rdata = mtval;
      ADDR_MCYCLE:    csr_rdata = mcycle[31:0];
      ADDR_MCYCLEH:   csr_rdata = mcycle[63:32];
      ADDR_MINSTRET:  csr_rdata = minstret[31:0];
      ADDR_MINSTRETH: csr_rdata = minstret[63:32];
      ADDR_MHARTID:   csr_rdata = MHARTID;
      default:        csr_rdata = '0;
    endcase
  end

  // Read-modify-write data for CSRRW/CSRRS/CSRRC and immediate forms.
  always_comb begin
    operand = funct3[2] ? {27'b0, zimm} : rs1_data;
    wdata   = csr_rdata;
    case (funct3[1:0])
      2'b01:   wdata = operand;
      2'b10:   wdata = csr_rdata | operand;
      2'b11:   wdata = csr_rdata & ~operand;
      default: wdata = csr_rdata;
    endcase
  end

  // Run/redirect sequencer with registered redirect outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (trap || mret_fire) begin
            state       <= REDIRECT;
            redirect    <= 1'b1;
            redirect_pc <= trap ? mtvec : mepc;
          end else begin
            redirect <= 1'b0;
          end
        end
        REDIRECT: begin
          state    <= RUN;
          redirect <= 1'b0;
        end
        default: begin
          state    <= RUN;
          redirect <= 1'b0;
        end
      endcase
    end
  end

  // mstatus interrupt-enable stack: trap pushes, mret pops, else CSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie  <= 1'b0;
      mpie <= 1'b0;
    end else if (trap) begin
      mpie <= mie;
      mie  <= 1'b0;
    end else if (mret_fire) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (csr_we && (csr_addr == ADDR_MSTATUS)) begin
      mie  <= wdata[3];
      mpie <= wdata[7];
    end
  end

  // Trap state and plain read/write CSRs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec    <= MTVEC_INIT;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap) begin
      mepc   <= {pc[31:2], 2'b00};
      mcause <= is_illegal_ir ? CAUSE_ILLEGAL : CAUSE_ECALL;
      mtval  <= is_illegal_ir ? ir : '0;
    end else if (csr_we) begin
      case (csr_addr)
        ADDR_MTVEC:    mtvec    <= {wdata[31:2], 2'b00};
        ADDR_MSCRATCH: mscratch <= wdata;
        ADDR_MEPC:     mepc     <= {wdata[31:2], 2'b00};
        ADDR_MCAUSE:   mcause   <= wdata;
        ADDR_MTVAL:    mtval    <= wdata;
        default:       ;
      endcase
    end
  end

  // 64-bit counters; a write to either half replaces that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (csr_we && (csr_addr == ADDR_MCYCLE)) begin
        mcycle <= {mcycle[63:32], wdata};
      end else if (csr_we && (csr_addr == ADDR_MCYCLEH)) begin
        mcycle <= {wdata, mcycle[31:0]};
      end else begin
        mcycle <= mcycle + CW'(1);
      end

      if (csr_we && (csr_addr == ADDR_MINSTRET)) begin
        minstret <= {minstret[63:32], wdata};
      end else if (csr_we && (csr_addr == ADDR_MINSTRETH)) begin
        minstret <= {wdata, minstret[31:0]};
      end else if (retire) begin
        minstret <= minstret + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Testbench for csr_trap_unit: scoreboard of expected CSR reads and redirects.
module tb_csr_trap_unit;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        wr_csr_n;
  logic        is_illegal_ir;
  logic        is_ecall;
  logic        is_mret;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_checks;
  int n_fail;

  logic [31:0] rd_q[$];
  logic [32:0] redir_q[$];
  logic [31:0] exp_rd;
  logic [32:0] exp_redir;

  csr_trap_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid        (valid),
    .pc           (pc),
    .ir           (ir),
    .funct3       (funct3),
    .csr_addr     (csr_addr),
    .rs1_data     (rs1_data),
    .zimm         (zimm),
    .wr_csr_n     (wr_csr_n),
    .is_illegal_ir(is_illegal_ir),
    .is_ecall     (is_ecall),
    .is_mret      (is_mret),
    .csr_rdata    (csr_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus drivers only; comparisons live in the test tasks.
  task automatic drive_idle();
    valid = 1'b0; wr_csr_n = 1'b1; is_illegal_ir = 1'b0; is_ecall = 1'b0;
    is_mret = 1'b0; funct3 = 3'b000; rs1_data = '0; zimm = '0;
  endtask

  task automatic drive_peek(input logic [11:0] a);
    drive_idle();
    csr_addr = a;
  endtask

  task automatic drive_csr(input logic [11:0] a, input logic [2:0] f3,
                           input logic [31:0] rs1, input logic [4:0] z);
    drive_idle();
    valid = 1'b1; wr_csr_n = 1'b0; csr_addr = a; funct3 = f3;
    rs1_data = rs1; zimm = z; ir = {a, z, f3, 5'd1, 7'h73};
  endtask

  task automatic drive_trap(input logic ill, input logic [31:0] p, input logic [31:0] w);
    drive_idle();
    valid = 1'b1; is_illegal_ir = ill; is_ecall = !ill; pc = p; ir = w;
    csr_addr = 12'h000;
  endtask

  task automatic drive_mret();
    drive_idle();
    valid = 1'b1; is_mret = 1'b1; ir = 32'h3020_0073; csr_addr = 12'h302;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle(); pc = '0; ir = '0; csr_addr = 12'h305;
    #12;
    rd_q.push_back(32'h0000_0100);
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL reset_mtvec: got %h want %h", csr_rdata, exp_rd); end
    n_checks++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_redirect: got %b/%h want 0/00000000", redirect, redirect_pc);
    end
    @(negedge clk); rst_n = 1'b1;
    rd_q.push_back(32'd0); rd_q.push_back(32'd1); rd_q.push_back(32'd2);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      drive_peek(12'hB00); #1;
      exp_rd = rd_q.pop_front(); n_checks++;
      if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL reset_mcycle%0d: got %h want %h", i, csr_rdata, exp_rd); end
    end
  endtask

  task automatic test_mscratch();
    @(negedge clk); drive_csr(12'h340, 3'b001, 32'hDEAD_BEEF, 5'd0);
    rd_q.push_back(32'h0); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mscratch_old: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk); drive_peek(12'h340);
    rd_q.push_back(32'hDEAD_BEEF); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mscratch_new: got %h want %h", csr_rdata, exp_rd); end
  endtask

  task automatic test_mstatus();
    logic [2:0]  f3s [3];
    logic [31:0] ops [3];
    logic [31:0] olds[3];
    logic [31:0] news[3];
    f3s[0] = 3'b110; ops[0] = 32'd8;          olds[0] = 32'h1800; news[0] = 32'h1808;
    f3s[1] = 3'b111; ops[1] = 32'd8;          olds[1] = 32'h1808; news[1] = 32'h1800;
    f3s[2] = 3'b001; ops[2] = 32'hFFFF_FFFF;  olds[2] = 32'h1800; news[2] = 32'h1888;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_csr(12'h300, f3s[i], ops[i], ops[i][4:0]);
      rd_q.push_back(olds[i]); #1;
      exp_rd = rd_q.pop_front(); n_checks++;
      if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mstatus_old%0d: got %h want %h", i, csr_rdata, exp_rd); end
      @(negedge clk); drive_peek(12'h300);
      rd_q.push_back(news[i]); #1;
      exp_rd = rd_q.pop_front(); n_checks++;
      if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mstatus_new%0d: got %h want %h", i, csr_rdata, exp_rd); end
    end
  endtask

  task automatic test_illegal();
    logic [11:0] addrs[5];
    logic [31:0] vals [5];
    addrs[0] = 12'h341; vals[0] = 32'h0000_0200;
    addrs[1] = 12'h342; vals[1] = 32'd2;
    addrs[2] = 12'h343; vals[2] = 32'hFFFF_FFFF;
    addrs[3] = 12'h300; vals[3] = 32'h1880;
    addrs[4] = 12'hB02; vals[4] = 32'd4;
    @(negedge clk); drive_trap(1'b1, 32'h200, 32'hFFFF_FFFF);
    redir_q.push_back({1'b1, 32'h100});
    @(negedge clk);
    exp_redir = redir_q.pop_front(); n_checks++;
    if (redirect !== exp_redir[32] || redirect_pc !== exp_redir[31:0]) begin
      n_fail++; $display("FAIL illegal_redirect: got %b/%h want %b/%h", redirect, redirect_pc, exp_redir[32], exp_redir[31:0]);
    end
    drive_idle(); redir_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    exp_redir = redir_q.pop_front(); n_checks++;
    if (redirect !== exp_redir[32]) begin n_fail++; $display("FAIL illegal_redirect_end: got %b want 0", redirect); end
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      drive_peek(addrs[i]); rd_q.push_back(vals[i]); #1;
      exp_rd = rd_q.pop_front(); n_checks++;
      if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL illegal_csr_%h: got %h want %h", addrs[i], csr_rdata, exp_rd); end
    end
  endtask

  task automatic test_ecall_mret();
    @(negedge clk); drive_csr(12'h300, 3'b110, 32'h0, 5'd8);
    @(negedge clk); drive_trap(1'b0, 32'h300, 32'h0000_0073);
    redir_q.push_back({1'b1, 32'h100});
    @(negedge clk);
    exp_redir = redir_q.pop_front(); n_checks++;
    if (redirect !== exp_redir[32] || redirect_pc !== exp_redir[31:0]) begin
      n_fail++; $display("FAIL ecall_redirect: got %b/%h want %b/%h", redirect, redirect_pc, exp_redir[32], exp_redir[31:0]);
    end
    drive_mret(); redir_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    exp_redir = redir_q.pop_front(); n_checks++;
    if (redirect !== exp_redir[32]) begin n_fail++; $display("FAIL flushed_mret_ignored: got %b want 0", redirect); end
    drive_peek(12'h342); rd_q.push_back(32'd11); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL ecall_mcause: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk); drive_peek(12'h343); rd_q.push_back(32'd0); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL ecall_mtval: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk); drive_peek(12'h300); rd_q.push_back(32'h1880); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL ecall_mstatus: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk); drive_mret(); redir_q.push_back({1'b1, 32'h300});
    @(negedge clk);
    exp_redir = redir_q.pop_front(); n_checks++;
    if (redirect !== exp_redir[32] || redirect_pc !== exp_redir[31:0]) begin
      n_fail++; $display("FAIL mret_redirect: got %b/%h want %b/%h", redirect, redirect_pc, exp_redir[32], exp_redir[31:0]);
    end
    drive_peek(12'h300); rd_q.push_back(32'h1888); redir_q.push_back({1'b0, 32'h0}); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mret_mstatus: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk);
    exp_redir = redir_q.pop_front(); n_checks++;
    if (redirect !== exp_redir[32]) begin n_fail++; $display("FAIL mret_redirect_end: got %b want 0", redirect); end
    drive_peek(12'hB02); rd_q.push_back(32'd6); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mret_minstret: got %h want %h", csr_rdata, exp_rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive_csr(12'h305, 3'b001, 32'h0000_0503, 5'd0);
    @(negedge clk); drive_trap(1'b0, 32'h600, 32'h0000_0073);
    redir_q.push_back({1'b1, 32'h500});
    @(negedge clk);
    exp_redir = redir_q.pop_front(); n_checks++;
    if (redirect !== exp_redir[32] || redirect_pc !== exp_redir[31:0]) begin
      n_fail++; $display("FAIL mtvec_fwd_redirect: got %b/%h want %b/%h", redirect, redirect_pc, exp_redir[32], exp_redir[31:0]);
    end
    drive_idle();
    @(negedge clk); drive_csr(12'h341, 3'b001, 32'h0000_0447, 5'd0);
    @(negedge clk); drive_mret(); redir_q.push_back({1'b1, 32'h444});
    @(negedge clk);
    exp_redir = redir_q.pop_front(); n_checks++;
    if (redirect !== exp_redir[32] || redirect_pc !== exp_redir[31:0]) begin
      n_fail++; $display("FAIL mepc_fwd_redirect: got %b/%h want %b/%h", redirect, redirect_pc, exp_redir[32], exp_redir[31:0]);
    end
    drive_peek(12'h305); rd_q.push_back(32'h500); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mtvec_masked: got %h want %h", csr_rdata, exp_rd); end
  endtask

  task automatic test_counters();
    logic [11:0] addrs[5];
    logic [31:0] vals [5];
    @(negedge clk); drive_csr(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'd0);
    @(negedge clk); drive_csr(12'hB80, 3'b001, 32'h0, 5'd0);
    rd_q.push_back(32'h0); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mcycleh_old: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk); drive_peek(12'hB00); rd_q.push_back(32'hFFFF_FFFF); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mcycle_held: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk); drive_peek(12'hB00); rd_q.push_back(32'h0); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mcycle_wrap: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk); drive_peek(12'hB80); rd_q.push_back(32'h1); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mcycleh_carry: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk); drive_csr(12'hF14, 3'b001, 32'h55, 5'd0);
    @(negedge clk); drive_csr(12'h7C0, 3'b001, 32'h1234, 5'd0);
    @(negedge clk); drive_csr(12'hB02, 3'b001, 32'h10, 5'd0);
    addrs[0] = 12'hF14; vals[0] = 32'h0;
    addrs[1] = 12'h7C0; vals[1] = 32'h0;
    addrs[2] = 12'hB02; vals[2] = 32'h10;
    addrs[3] = 12'hB82; vals[3] = 32'h0;
    addrs[4] = 12'h340; vals[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive_peek(addrs[i]); rd_q.push_back(vals[i]); #1;
      exp_rd = rd_q.pop_front(); n_checks++;
      if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL counters_csr_%h: got %h want %h", addrs[i], csr_rdata, exp_rd); end
    end
  endtask

  task automatic test_reset_mid_redirect();
    @(negedge clk); drive_trap(1'b0, 32'h700, 32'h0000_0073);
    @(negedge clk); drive_idle();
    n_checks++;
    if (redirect !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pre: got %b want 1", redirect); end
    rst_n = 1'b0; #1;
    n_checks++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_async: got %b/%h want 0/00000000", redirect, redirect_pc);
    end
    csr_addr = 12'h305; rd_q.push_back(32'h100); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mid_reset_mtvec: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); drive_csr(12'h340, 3'b001, 32'h0000_A5A5, 5'd0);
    rd_q.push_back(32'h0); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mid_reset_mscratch_old: got %h want %h", csr_rdata, exp_rd); end
    @(negedge clk); drive_peek(12'h340); rd_q.push_back(32'h0000_A5A5); #1;
    exp_rd = rd_q.pop_front(); n_checks++;
    if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL mid_reset_run_write: got %h want %h", csr_rdata, exp_rd); end
    n_checks++;
    if (redirect !== 1'b0) begin n_fail++; $display("FAIL mid_reset_redirect_low: got %b want 0", redirect); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mscratch();
    test_mstatus();
    test_illegal();
    test_ecall_mret();
    test_back_to_back();
    test_counters();
    test_reset_mid_redirect();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
